// File: rtl/pairing_host_pkg.sv
// +----------------------------------------------------------------------+
// | pairing_host_pkg : shared encodings for the pairing serial host      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package pairing_host_pkg;

    localparam int WIDTH = 198;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_RUN   = 2'b10;
    localparam logic [1:0] OP_ILL   = 2'b11;

    // Operand and result register map of the pairing core
    localparam logic [5:0] XP   = 6'd3;
    localparam logic [5:0] YP   = 6'd5;
    localparam logic [5:0] XQ   = 6'd6;
    localparam logic [5:0] YQ   = 6'd7;
    localparam logic [5:0] RES0 = 6'd9;
    localparam logic [5:0] RES1 = 6'd10;
    localparam logic [5:0] RES2 = 6'd11;
    localparam logic [5:0] RES3 = 6'd12;
    localparam logic [5:0] RES4 = 6'd13;
    localparam logic [5:0] RES5 = 6'd14;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_W_UPD    = 4'd1,
        ST_W_SHIFT  = 4'd2,
        ST_W_COMMIT = 4'd3,
        ST_R_SETUP  = 4'd4,
        ST_R_UPD    = 4'd5,
        ST_R_SHIFT  = 4'd6,
        ST_RUN      = 4'd7,
        ST_RESP     = 4'd8
    } state_t;

endpackage

`default_nettype wire

// File: rtl/pairing_host_shreg.sv
// +----------------------------------------------------------------------+
// | pairing_host_shreg : parallel-load / shift-right word register       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module pairing_host_shreg #(
    parameter int WIDTH = 198
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    input  logic             serial_in,
    output logic             serial_out,
    output logic [WIDTH-1:0] q
);

    // Load wins over shift; serial data enters at the MSB so an LSB-first
    // stream is fully assembled after WIDTH shifts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift) begin
            q <= {serial_in, q[WIDTH-1:1]};
        end
    end

    assign serial_out = q[0];

endmodule

`default_nettype wire

// File: rtl/pairing_serial_host.sv
// +----------------------------------------------------------------------+
// | pairing_serial_host : command/response bridge to the pairing core's  |
// | bit-serial register port.                         Revision: 1.0      |
// +----------------------------------------------------------------------+
`default_nettype none

module pairing_serial_host #(
    parameter int WIDTH  = pairing_host_pkg::WIDTH,
    parameter int ADDR_W = 6,
    parameter int TMO_W  = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [WIDTH-1:0]  cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_data,
    output logic              rsp_err,
    output logic              core_reset,
    output logic              core_sel,
    output logic              core_update,
    output logic              core_ready,
    output logic              core_w,
    output logic              core_i,
    output logic [ADDR_W-1:0] core_addr,
    input  logic              core_o,
    input  logic              core_done
);

    import pairing_host_pkg::*;

    localparam logic [7:0]       LAST_BIT = 8'(WIDTH - 1);
    // Exiting when the counter is one short of all-ones gives 2^TMO_W-1 RUN cycles
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    state_t             state, state_d;
    logic [7:0]         bit_cnt, bit_cnt_d;
    logic [TMO_W-1:0]   tmo_cnt, tmo_cnt_d;
    logic               done_q;
    logic               accept;
    logic               done_rise;

    logic               sh_load;
    logic               sh_shift;
    logic               sh_out;
    logic [WIDTH-1:0]   sh_q;

    logic               cmd_ready_d, rsp_valid_d, rsp_err_d;
    logic [WIDTH-1:0]   rsp_data_d;
    logic               core_reset_d, core_sel_d, core_update_d;
    logic               core_ready_d, core_w_d, core_i_d;
    logic [ADDR_W-1:0]  core_addr_d;

    assign accept    = cmd_valid && cmd_ready;
    assign done_rise = core_done && !done_q;

    pairing_host_shreg #(
        .WIDTH (WIDTH)
    ) u_shreg (
        .clk        (clk),
        .reset      (reset),
        .load       (sh_load),
        .load_data  (cmd_data),
        .shift      (sh_shift),
        .serial_in  (core_o),
        .serial_out (sh_out),
        .q          (sh_q)
    );

    always_comb begin
        state_d    = state;
        rsp_data_d = rsp_data;
        rsp_err_d  = rsp_err;
        sh_load    = 1'b0;
        sh_shift   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_WRITE: begin
                            state_d = ST_W_UPD;
                            sh_load = 1'b1;
                        end
                        OP_READ:  state_d = ST_R_SETUP;
                        OP_RUN:   state_d = ST_RUN;
                        default: begin
                            state_d    = ST_RESP;
                            rsp_data_d = '0;
                            rsp_err_d  = 1'b1;
                        end
                    endcase
                end
            end
            ST_W_UPD:   state_d = ST_W_SHIFT;
            ST_W_SHIFT: begin
                if (bit_cnt == LAST_BIT) begin
                    state_d = ST_W_COMMIT;
                end
            end
            ST_W_COMMIT: begin
                state_d    = ST_RESP;
                rsp_data_d = '0;
                rsp_err_d  = 1'b0;
            end
            ST_R_SETUP: state_d = ST_R_UPD;
            ST_R_UPD:   state_d = ST_R_SHIFT;
            ST_R_SHIFT: begin
                sh_shift = 1'b1;
                if (bit_cnt == LAST_BIT) begin
                    state_d    = ST_RESP;
                    rsp_data_d = {core_o, sh_q[WIDTH-1:1]};
                    rsp_err_d  = 1'b0;
                end
            end
            ST_RUN: begin
                if (done_rise) begin
                    state_d    = ST_RESP;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b0;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_d    = ST_RESP;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // core_i is registered, so the bit for the next shift cycle is
        // taken from the shreg one cycle ahead and the shreg advances with it.
        if (state_d == ST_W_SHIFT) begin
            sh_shift = 1'b1;
        end

        if (state_d != state) begin
            bit_cnt_d = '0;
        end else if (state == ST_W_SHIFT || state == ST_R_SHIFT) begin
            bit_cnt_d = bit_cnt + 8'd1;
        end else begin
            bit_cnt_d = bit_cnt;
        end

        tmo_cnt_d = (state == ST_RUN) ? tmo_cnt + 1'b1 : '0;

        // Registered outputs are decoded from the state being entered
        cmd_ready_d   = (state_d == ST_IDLE);
        rsp_valid_d   = (state_d == ST_RESP);
        core_reset_d  = core_reset;
        core_addr_d   = core_addr;
        core_sel_d    = 1'b0;
        core_update_d = 1'b0;
        core_ready_d  = 1'b0;
        core_w_d      = 1'b0;
        core_i_d      = 1'b0;

        case (state_d)
            ST_W_UPD: begin
                core_reset_d  = 1'b1;
                core_sel_d    = 1'b1;
                core_update_d = 1'b1;
                core_addr_d   = cmd_addr;
            end
            ST_W_SHIFT: begin
                core_sel_d   = 1'b1;
                core_ready_d = 1'b1;
                core_i_d     = sh_out;
            end
            ST_W_COMMIT: begin
                core_sel_d = 1'b1;
                core_w_d   = 1'b1;
            end
            ST_R_SETUP: begin
                core_sel_d  = 1'b1;
                core_addr_d = cmd_addr;
            end
            ST_R_UPD: begin
                core_sel_d    = 1'b1;
                core_update_d = 1'b1;
            end
            ST_R_SHIFT: begin
                core_sel_d   = 1'b1;
                core_ready_d = 1'b1;
            end
            ST_RUN: core_reset_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            tmo_cnt     <= '0;
            done_q      <= 1'b0;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
            core_reset  <= 1'b1;
            core_sel    <= 1'b0;
            core_update <= 1'b0;
            core_ready  <= 1'b0;
            core_w      <= 1'b0;
            core_i      <= 1'b0;
            core_addr   <= '0;
        end else begin
            state       <= state_d;
            bit_cnt     <= bit_cnt_d;
            tmo_cnt     <= tmo_cnt_d;
            done_q      <= core_done;
            cmd_ready   <= cmd_ready_d;
            rsp_valid   <= rsp_valid_d;
            rsp_data    <= rsp_data_d;
            rsp_err     <= rsp_err_d;
            core_reset  <= core_reset_d;
            core_sel    <= core_sel_d;
            core_update <= core_update_d;
            core_ready  <= core_ready_d;
            core_w      <= core_w_d;
            core_i      <= core_i_d;
            core_addr   <= core_addr_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pairing_serial_host.sv
// +----------------------------------------------------------------------+
// | tb_pairing_serial_host : bench for pairing_serial_host with a        |
// | behavioural serial core model.                    Revision: 1.0      |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_pairing_serial_host;

    import pairing_host_pkg::*;

    localparam int W       = 198;
    localparam int AW      = 6;
    localparam int DONE_AT = 5000;

    localparam logic [W-1:0] D3   = 198'h21181940120548aa020568aa65a5989609251595a89a44598;
    localparam logic [W-1:0] D7   = 198'h0a905590506a8a845592a09644a2095291422910a968a5048;
    localparam logic [W-1:0] R9   = 198'h09a49266428495042842965645266a2164a1268408a669866;
    localparam logic [W-1:0] D5   = {6'h2a, {12{16'hbeef}}};
    localparam logic [W-1:0] D6   = {6'h15, {12{16'h1357}}};
    localparam logic [W-1:0] D6B  = {6'h3f, {12{16'hc0de}}};

    typedef struct {
        logic [1:0]    op;
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
        logic [W-1:0]  exp_data;
        logic          exp_err;
        int            exp_lat;
    } vec_t;

    typedef struct {
        logic [W-1:0] data;
        logic         err;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // Main instance
    logic          cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr, core_addr;
    logic [W-1:0]  cmd_data, rsp_data;
    logic          core_reset, core_sel, core_update, core_ready, core_w, core_i;
    logic          core_o, core_done;

    // Short-timeout instance
    logic          b_cmd_valid, b_cmd_ready, b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [1:0]    b_cmd_op;
    logic [AW-1:0] b_cmd_addr, b_core_addr;
    logic [W-1:0]  b_cmd_data, b_rsp_data;
    logic          b_core_reset, b_core_sel, b_core_update, b_core_ready, b_core_w, b_core_i;
    logic          b_core_o, b_core_done;

    pairing_serial_host #(.WIDTH(W), .ADDR_W(AW), .TMO_W(24)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .core_reset(core_reset), .core_sel(core_sel), .core_update(core_update),
        .core_ready(core_ready), .core_w(core_w), .core_i(core_i), .core_addr(core_addr),
        .core_o(core_o), .core_done(core_done)
    );

    pairing_serial_host #(.WIDTH(W), .ADDR_W(AW), .TMO_W(4)) dut_tmo (
        .clk(clk), .reset(reset),
        .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_op(b_cmd_op),
        .cmd_addr(b_cmd_addr), .cmd_data(b_cmd_data),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data), .rsp_err(b_rsp_err),
        .core_reset(b_core_reset), .core_sel(b_core_sel), .core_update(b_core_update),
        .core_ready(b_core_ready), .core_w(b_core_w), .core_i(b_core_i), .core_addr(b_core_addr),
        .core_o(b_core_o), .core_done(b_core_done)
    );

    assign b_core_o    = 1'b0;
    assign b_core_done = 1'b0;

    // Behavioural core: register file behind a shift register, done after DONE_AT run cycles
    logic [W-1:0] regs [0:63];
    logic [W-1:0] sr;
    int           run_cnt;
    logic         done_m;

    assign core_o    = sr[0];
    assign core_done = done_m;

    always @(posedge clk) begin
        if (core_reset) begin
            run_cnt <= 0;
            done_m  <= 1'b0;
        end else if (run_cnt < DONE_AT) begin
            run_cnt <= run_cnt + 1;
        end else if (!done_m) begin
            done_m    <= 1'b1;
            regs[RES0] <= R9;
        end
        if (core_sel && core_update) sr <= regs[core_addr];
        else if (core_ready)         sr <= {core_i, sr[W-1:1]};
        if (core_w) regs[core_addr] <= sr;
    end

    // Port-activity monitor, restarted whenever a new command is accepted
    int           txn_id = 0;
    int           seen_id = 0;
    int           m_upd, m_rdy, m_w, m_sel, m_rl;
    logic [W-1:0] cap;

    always @(negedge clk) begin
        if (seen_id != txn_id) begin
            seen_id = txn_id;
            m_upd = 0; m_rdy = 0; m_w = 0; m_sel = 0; m_rl = 0;
            cap = '0;
        end
        if (core_update) m_upd++;
        if (core_w)      m_w++;
        if (core_sel)    m_sel++;
        if (!core_reset) m_rl++;
        if (core_ready) begin
            if (m_rdy < W) cap[m_rdy] = core_i;
            m_rdy++;
        end
    end

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    vec_t vecs [8];

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic put_cmd(input logic [1:0] op, input logic [AW-1:0] addr, input logic [W-1:0] data,
                           input logic [W-1:0] exp_data, input logic exp_err);
        int n = 0;
        while (!cmd_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("cmd_ready before issue", W'(cmd_ready), W'(1));
        cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_data = ~data; cmd_op = OP_ILL; cmd_addr = ~addr;
        sb.push_back('{exp_data, exp_err});
        txn_id++;
    endtask

    task automatic get_rsp(input string name, input int hold, output int lat);
        exp_t e;
        int   bad = 0;
        e.data = '0;
        e.err  = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 300) begin
            @(posedge clk); #1; lat++;
        end
        chk({name, " rsp_valid"}, W'(rsp_valid), W'(1));
        chk({name, " scoreboard entry"}, W'(sb.size() > 0), W'(1));
        if (sb.size() > 0) e = sb.pop_front();
        chk({name, " rsp_data"}, rsp_data, e.data);
        chk({name, " rsp_err"}, W'(rsp_err), W'(e.err));
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            if (!rsp_valid || rsp_data !== e.data || rsp_err !== e.err || cmd_ready) bad++;
        end
        if (hold > 0) chk({name, " held response stable"}, W'(bad), '0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int rise_at;
        int rl_hi;
        cmd_valid = 1'b0; cmd_op = OP_WRITE; cmd_addr = '0; cmd_data = '0; rsp_ready = 1'b0;
        b_cmd_valid = 1'b0; b_cmd_op = OP_WRITE; b_cmd_addr = '0; b_cmd_data = '0; b_rsp_ready = 1'b0;

        vecs[0] = '{OP_WRITE, XP, D3, '0, 1'b0, 200};
        vecs[1] = '{OP_WRITE, YP, D5, '0, 1'b0, 200};
        vecs[2] = '{OP_WRITE, XQ, D6, '0, 1'b0, 200};
        vecs[3] = '{OP_WRITE, YQ, D7, '0, 1'b0, 200};
        vecs[4] = '{OP_READ,  YQ, '0, D7, 1'b0, 200};
        vecs[5] = '{OP_READ,  XP, '0, D3, 1'b0, 200};
        vecs[6] = '{OP_ILL,   XP, D5, '0, 1'b1, 0};
        vecs[7] = '{OP_READ,  YP, '0, D5, 1'b0, 200};

        repeat (3) @(posedge clk);
        #1;
        chk("reset flags", W'({core_reset, core_sel, core_update, core_ready, core_w, core_i,
                               cmd_ready, rsp_valid, rsp_err}), W'(9'b1_0000_0000));
        chk("reset core_addr", W'(core_addr), '0);
        chk("reset rsp_data", rsp_data, '0);
        reset = 1'b1;
        chk("cmd_ready before first edge", W'(cmd_ready), '0);
        @(posedge clk); #1;
        chk("cmd_ready after release", W'(cmd_ready), W'(1));

        for (int i = 0; i < 8; i++) begin
            put_cmd(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].exp_data, vecs[i].exp_err);
            get_rsp($sformatf("v%0d", i), 0, lat);
            chk($sformatf("v%0d latency", i), W'(lat), W'(vecs[i].exp_lat));
            if (vecs[i].op == OP_WRITE) begin
                chk($sformatf("v%0d update cycles", i), W'(m_upd), W'(1));
                chk($sformatf("v%0d ready cycles", i), W'(m_rdy), W'(W));
                chk($sformatf("v%0d w pulses", i), W'(m_w), W'(1));
                chk($sformatf("v%0d core_reset low cycles", i), W'(m_rl), '0);
                chk($sformatf("v%0d serial stream", i), cap, vecs[i].data);
            end else if (vecs[i].op == OP_READ) begin
                chk($sformatf("v%0d ready cycles", i), W'(m_rdy), W'(W));
                chk($sformatf("v%0d w pulses", i), W'(m_w), '0);
            end else begin
                chk($sformatf("v%0d sel cycles", i), W'(m_sel), '0);
            end
        end

        // Run to completion against the core model
        put_cmd(OP_RUN, '0, '0, '0, 1'b0);
        lat = 0; rise_at = -1; rl_hi = 0;
        while (!rsp_valid && lat < 6000) begin
            if (core_reset) rl_hi++;
            @(posedge clk); #1; lat++;
            if (core_done && rise_at < 0) rise_at = lat;
        end
        chk("run rsp_valid", W'(rsp_valid), W'(1));
        chk("run rsp one cycle after done", W'(lat), W'(rise_at + 1));
        chk("run core_reset high cycles", W'(rl_hi), '0);
        get_rsp("run", 0, lat);
        chk("core_reset stays low after run", W'(core_reset), '0);
        put_cmd(OP_READ, RES0, '0, R9, 1'b0);
        get_rsp("read res0", 0, lat);
        chk("read res0 latency", W'(lat), W'(200));

        // Timeout on the short-timeout instance
        chk("tmo cmd_ready", W'(b_cmd_ready), W'(1));
        b_cmd_op = OP_RUN; b_cmd_valid = 1'b1;
        @(posedge clk); #1;
        b_cmd_valid = 1'b0;
        lat = 0; rl_hi = 0;
        while (!b_rsp_valid && lat < 100) begin
            if (b_core_reset) rl_hi++;
            @(posedge clk); #1; lat++;
        end
        chk("tmo latency", W'(lat), W'(15));
        chk("tmo rsp_err", W'(b_rsp_err), W'(1));
        chk("tmo rsp_data", b_rsp_data, '0);
        chk("tmo core_reset high cycles", W'(rl_hi), '0);
        b_rsp_ready = 1'b1;
        @(posedge clk); #1;
        b_rsp_ready = 1'b0;
        chk("tmo back to idle", W'(b_cmd_ready), W'(1));

        // Asynchronous reset part-way through a write
        put_cmd(OP_WRITE, XQ, D6B, '0, 1'b0);
        repeat (101) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("mid-reset flags", W'({core_reset, core_sel, core_update, core_ready, core_w, core_i,
                                   cmd_ready, rsp_valid, rsp_err}), W'(9'b1_0000_0000));
        chk("mid-reset core_addr", W'(core_addr), '0);
        sb.delete();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("post-reset cmd_ready", W'(cmd_ready), W'(1));
        chk("post-reset no response", W'(rsp_valid), '0);
        put_cmd(OP_WRITE, XQ, D6B, '0, 1'b0);
        get_rsp("rewrite", 0, lat);
        chk("rewrite latency", W'(lat), W'(200));
        chk("rewrite serial stream", cap, D6B);
        put_cmd(OP_READ, XQ, '0, D6B, 1'b0);
        get_rsp("reread", 0, lat);

        // Response held off by rsp_ready
        put_cmd(OP_READ, YQ, '0, D7, 1'b0);
        get_rsp("held read", 10, lat);
        chk("held read latency", W'(lat), W'(200));
        chk("idle after handshake", W'(cmd_ready), W'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
